// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel front end: geometry defaults, a constant
// clog2 and the slice-index macro used to address packed pixel columns.
`ifndef SOBEL_PKG_SV
`define SOBEL_PKG_SV

package sobel_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_LINE_W = 640;
   localparam int DEF_IMG_H  = 480;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// Part-select of pixel k in a packed vector of w-bit pixels.
`define SOBEL_SLICE(k, w) (k)*(w) +: (w)

`endif

// File: rtl/line_fifo.sv
// Single-line delay: a LINE_W deep RAM addressed by the shared line pointer,
// popping the entry at ptr_i while the new pixel overwrites it.
module line_fifo
   import sobel_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_i,
   input  logic [clog2(LINE_W)-1:0] ptr_i,
   input  logic [DATA_W-1:0]        data_i,
   output logic [DATA_W-1:0]        data_o
);

   localparam int AW = clog2(LINE_W);

   logic [DATA_W-1:0] mem [LINE_W];
   logic [DATA_W-1:0] rd_data_reg;
   logic [AW-1:0]     rd_addr;

   // The registered read prefetches the slot the pointer moves to next, so the
   // entry popped on an accepted pixel is already sitting in rd_data_reg.
   // After a write the next slot is always a different address (LINE_W >= 2).
   always_comb begin
      rd_addr = ptr_i;
      if (we_i) begin
         rd_addr = (ptr_i == AW'(LINE_W - 1)) ? '0 : ptr_i + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[ptr_i] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_reg <= '0;
      end else begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign data_o = rd_data_reg;

endmodule

// File: rtl/param_line_buffer.sv
// Multi-row line buffer presenting a NUM_ROWS pixel column per accepted pixel,
// with frame position, window-valid and end-of-frame outputs.
// Optional LINE_BUFFER_BORDER_REPLICATE_EN: top-border replication, valid from row 0.
module param_line_buffer
   import sobel_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LINE_W   = DEF_LINE_W,
   parameter int IMG_H    = DEF_IMG_H,
   parameter int NUM_ROWS = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we_i,
   input  logic                       sof_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic [NUM_ROWS*DATA_W-1:0] rows_o,
   output logic [clog2(LINE_W)-1:0]   col_o,
   output logic [clog2(IMG_H)-1:0]    row_o,
   output logic                       valid_o,
   output logic                       done_o
);

   localparam int CW = clog2(LINE_W);
   localparam int RW = clog2(IMG_H);

   // col_reg doubles as the shared FIFO pointer: both step per accepted pixel,
   // wrap at LINE_W and return to 0 on start of frame.
   logic [CW-1:0] col_reg;
   logic [RW-1:0] row_reg;
   logic [CW-1:0] pos_col;
   logic [RW-1:0] pos_row;
   logic          sof_accept;
   logic          last_pix;
   logic          valid_next;

   logic [NUM_ROWS-1:0][DATA_W-1:0] tap;
   logic [NUM_ROWS*DATA_W-1:0]      rows_next;

   assign sof_accept = we_i && sof_i;
   assign pos_col    = sof_accept ? '0 : col_reg;
   assign pos_row    = sof_accept ? '0 : row_reg;
   // A resynced pixel sits at row 0, so it can never be flagged as last.
   assign last_pix   = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(LINE_W - 1));

   assign tap[0] = data_i;

   generate
      for (genvar gi = 0; gi < NUM_ROWS - 1; gi++) begin : g_fifo
         line_fifo #(
            .DATA_W (DATA_W),
            .LINE_W (LINE_W)
         ) u_line_fifo (
            .clk    (clk),
            .rst    (rst),
            .we_i   (we_i),
            .ptr_i  (pos_col),
            .data_i (tap[gi]),
            .data_o (tap[gi+1])
         );
      end
   endgenerate

`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
   generate
      for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_replicate
         logic [DATA_W-1:0] rep;
         // Rows above the frame top take the topmost real line (slice pos_row).
         always_comb begin
            rep = tap[gi];
            for (int j = 0; j < gi; j++) begin
               if (pos_row == RW'(j)) begin
                  rep = tap[j];
               end
            end
         end
         assign rows_next[`SOBEL_SLICE(gi, DATA_W)] = rep;
      end
   endgenerate
   assign valid_next = 1'b1;
`else
   assign rows_next  = tap;
   assign valid_next = (pos_row >= RW'(NUM_ROWS - 1));
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_reg <= '0;
         row_reg <= '0;
         rows_o  <= '0;
         col_o   <= '0;
         row_o   <= '0;
         valid_o <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         done_o  <= 1'b0;
         if (we_i) begin
            rows_o  <= rows_next;
            col_o   <= pos_col;
            row_o   <= pos_row;
            valid_o <= valid_next;
            done_o  <= last_pix;
            if (pos_col == CW'(LINE_W - 1)) begin
               col_reg <= '0;
               row_reg <= (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
            end else begin
               col_reg <= pos_col + 1'b1;
               row_reg <= pos_row;
            end
         end
      end
   end

endmodule

// File: tb/tb_param_line_buffer.sv
// Self-checking bench for param_line_buffer (LINE_W=4, IMG_H=4, NUM_ROWS=3):
// a frame-memory model feeds a scoreboard checked on every accepted pixel.
module tb_param_line_buffer;

   localparam int DW = 8;
   localparam int LW = 4;
   localparam int IH = 4;
   localparam int NR = 3;

   logic              clk;
   logic              rst;
   logic              we;
   logic              sof;
   logic [DW-1:0]     data;
   logic [NR*DW-1:0]  rows;
   logic [1:0]        col;
   logic [1:0]        row;
   logic              valid;
   logic              done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NR*DW-1:0] rows;
      logic [1:0]       col;
      logic [1:0]       row;
      logic             valid;
      logic             done;
      logic             chk_rows;
   } exp_t;

   exp_t        sb[$];
   int          m_row;
   int          m_col;
   logic [7:0]  pix [IH][LW];

   param_line_buffer #(
      .DATA_W   (DW),
      .LINE_W   (LW),
      .IMG_H    (IH),
      .NUM_ROWS (NR)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .sof_i   (sof),
      .data_i  (data),
      .rows_o  (rows),
      .col_o   (col),
      .row_o   (row),
      .valid_o (valid),
      .done_o  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every accepted pixel yields one registered output.
   always @(posedge clk) begin
      exp_t e;
      if (rst && we) begin
         #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: output seen with no expected entry");
         end else begin
            e = sb.pop_front();
            if (valid !== e.valid || done !== e.done || col !== e.col || row !== e.row ||
                (e.chk_rows && rows !== e.rows)) begin
               errors++;
               $display("FAIL sb_out got v=%0b d=%0b c=%0d r=%0d rows=%h want v=%0b d=%0b c=%0d r=%0d rows=%h",
                        valid, done, col, row, rows, e.valid, e.done, e.col, e.row, e.rows);
            end
         end
      end
   end

   task automatic model_reset();
      m_row = 0;
      m_col = 0;
      sb.delete();
   endtask

   // Drive one pixel for one edge and queue the frame model's prediction.
   task automatic drive_pix(input logic [7:0] d, input logic s);
      exp_t e;
      int   r;
      we   = 1'b1;
      data = d;
      sof  = s;
      if (s) begin
         m_row = 0;
         m_col = 0;
      end
      pix[m_row][m_col] = d;
      e.col  = 2'(m_col);
      e.row  = 2'(m_row);
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
      e.valid = 1'b1;
`else
      e.valid = (m_row >= NR - 1);
`endif
      e.done = (m_row == IH - 1) && (m_col == LW - 1);
      e.rows = '0;
      for (int k = 0; k < NR; k++) begin
         r = m_row - k;
         if (r < 0) r = 0;
         e.rows[k*DW +: DW] = pix[r][m_col];
      end
      e.chk_rows = e.valid;
      sb.push_back(e);
      if (m_col == LW - 1) begin
         m_col = 0;
         m_row = (m_row == IH - 1) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
      @(posedge clk);
      #2;
      we  = 1'b0;
      sof = 1'b0;
   endtask

   task automatic idle(input int n);
      we  = 1'b0;
      sof = 1'b0;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      we   = 1'b1;
      sof  = 1'b0;
      data = 8'hAA;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (rows !== '0 || col !== 2'd0 || row !== 2'd0 || valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got rows=%h c=%0d r=%0d v=%0b d=%0b want all zero",
                  rows, col, row, valid, done);
      end
      we  = 1'b0;
      rst = 1'b1;
      model_reset();
      idle(2);
   endtask

   task automatic test_stream();
      for (int p = 1; p <= 9; p++) begin
         drive_pix(8'(p), p == 1);
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
         if (p == 1) begin
            checks++;
            if (valid !== 1'b1 || rows !== 24'h010101) begin
               errors++;
               $display("FAIL replicate_row0 got v=%0b rows=%h want v=1 rows=010101", valid, rows);
            end
         end
         if (p == 5) begin
            checks++;
            if (valid !== 1'b1 || rows !== 24'h010105) begin
               errors++;
               $display("FAIL replicate_row1 got v=%0b rows=%h want v=1 rows=010105", valid, rows);
            end
         end
`else
         if (p == 8) begin
            checks++;
            if (valid !== 1'b0) begin
               errors++;
               $display("FAIL priming_valid got %0b want 0", valid);
            end
         end
`endif
      end
      checks++;
      if (valid !== 1'b1 || rows !== 24'h010509 || row !== 2'd2 || col !== 2'd0) begin
         errors++;
         $display("FAIL first_window got v=%0b rows=%h r=%0d c=%0d want v=1 rows=010509 r=2 c=0",
                  valid, rows, row, col);
      end
   endtask

   task automatic test_gaps();
      drive_pix(8'd10, 1'b0);
      for (int g = 0; g < 3; g++) begin
         idle(1);
         checks++;
         if (valid !== 1'b0 || done !== 1'b0 || rows !== 24'h02060A || col !== 2'd1 || row !== 2'd2) begin
            errors++;
            $display("FAIL gap_hold got v=%0b d=%0b rows=%h c=%0d r=%0d want v=0 d=0 rows=02060a c=1 r=2",
                     valid, done, rows, col, row);
         end
      end
      drive_pix(8'd11, 1'b0);
      checks++;
      if (valid !== 1'b1 || rows !== 24'h03070B) begin
         errors++;
         $display("FAIL after_gap got v=%0b rows=%h want v=1 rows=03070b", valid, rows);
      end
   endtask

   task automatic test_end_of_frame();
      for (int p = 12; p <= 16; p++) begin
         drive_pix(8'(p), 1'b0);
      end
      checks++;
      if (done !== 1'b1 || valid !== 1'b1 || rows !== 24'h080C10) begin
         errors++;
         $display("FAIL frame_end got d=%0b v=%0b rows=%h want d=1 v=1 rows=080c10", done, valid, rows);
      end
      idle(1);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse got %0b want 0", done);
      end
      for (int p = 17; p <= 24; p++) begin
         drive_pix(8'(p), 1'b0);
      end
   endtask

   task automatic test_resync();
      for (int p = 1; p <= 6; p++) begin
         drive_pix(8'(p), p == 1);
      end
      drive_pix(8'd50, 1'b1);
      checks++;
      if (row !== 2'd0 || col !== 2'd0) begin
         errors++;
         $display("FAIL resync_pos got r=%0d c=%0d want r=0 c=0", row, col);
      end
`ifndef LINE_BUFFER_BORDER_REPLICATE_EN
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL resync_valid got %0b want 0", valid);
      end
`endif
      for (int p = 51; p <= 58; p++) begin
         drive_pix(8'(p), 1'b0);
      end
      checks++;
      if (valid !== 1'b1 || rows[7:0] !== 8'd58 || rows !== 24'h32363A) begin
         errors++;
         $display("FAIL resync_window got v=%0b rows=%h want v=1 rows=32363a", valid, rows);
      end
   endtask

   task automatic test_async_reset();
      for (int p = 1; p <= 12; p++) begin
         drive_pix(8'(p), p == 1);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (rows !== '0 || col !== 2'd0 || row !== 2'd0 || valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got rows=%h c=%0d r=%0d v=%0b d=%0b want all zero",
                  rows, col, row, valid, done);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      idle(1);
      for (int p = 1; p <= 16; p++) begin
         drive_pix(8'(p), p == 1);
         if (p == 9) begin
            checks++;
            if (valid !== 1'b1 || rows !== 24'h010509) begin
               errors++;
               $display("FAIL restream_window got v=%0b rows=%h want v=1 rows=010509", valid, rows);
            end
         end
      end
      checks++;
      if (done !== 1'b1 || rows !== 24'h080C10) begin
         errors++;
         $display("FAIL restream_end got d=%0b rows=%h want d=1 rows=080c10", done, rows);
      end
   endtask

   task automatic test_back_to_back_sof_last();
      // sof on what would be the frame's last pixel wins over done.
      for (int p = 1; p <= 15; p++) begin
         drive_pix(8'(p), p == 1);
      end
      drive_pix(8'd99, 1'b1);
      checks++;
      if (done !== 1'b0 || row !== 2'd0 || col !== 2'd0) begin
         errors++;
         $display("FAIL sof_on_last got d=%0b r=%0d c=%0d want d=0 r=0 c=0", done, row, col);
      end
   endtask

   initial begin
      we   = 1'b0;
      sof  = 1'b0;
      data = '0;
      rst  = 1'b0;
      m_row = 0;
      m_col = 0;
      test_reset();
      test_stream();
      test_gaps();
      test_end_of_frame();
      test_resync();
      test_async_reset();
      test_back_to_back_sof_last();
      idle(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d entries want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
